// File: rtl/lc3b_types.sv
// Shared word/line types and the memory-arbiter state encodings.
package lc3b_types;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned LINE_BITS  = 128;

    typedef logic [WORD_WIDTH-1:0] lc3b_word;
    typedef logic [LINE_BITS-1:0]  lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// The pmem side is a combinational mux of the granted cache; only state and last_grant are registers.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state;
    arb_state_t state_next;
    grant_t     last_grant;
    grant_t     last_grant_next;

    logic i_req;
    logic d_req;

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;

    // Read data fans out to both caches; each resp qualifies its copy.
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Every SERVE_x exits through IDLE, giving memory a low-strobe cycle between transactions.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = '0;
        pmem_wdata      = '0;
        icache_resp     = 1'b0;
        dcache_resp     = 1'b0;

        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant == GRANT_D)) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                end else if (d_req) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                end
            end

            SERVE_I: begin
                pmem_read    = icache_read;
                pmem_address = icache_address;
                icache_resp  = pmem_resp;
                if (pmem_resp || !i_req) begin
                    state_next = IDLE;
                end
            end

            SERVE_D: begin
                pmem_write   = dcache_write;
                pmem_read    = dcache_read & ~dcache_write;
                pmem_address = dcache_address;
                pmem_wdata   = dcache_wdata;
                dcache_resp  = pmem_resp;
                if (pmem_resp || !d_req) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-source traffic, tie-breaking, hold-off, abort and reset.
module tb_mem_arbiter;
    import lc3b_types::*;

    logic     clk;
    logic     rst;
    logic     icache_read;
    lc3b_word icache_address;
    lc3b_line icache_rdata;
    logic     icache_resp;
    logic     dcache_read;
    logic     dcache_write;
    lc3b_word dcache_address;
    lc3b_line dcache_wdata;
    lc3b_line dcache_rdata;
    logic     dcache_resp;
    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    int checks;
    int failures;

    mem_arbiter #(
        .ADDR_WIDTH(16),
        .LINE_WIDTH(128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_read   (icache_read),
        .icache_address(icache_address),
        .icache_rdata  (icache_rdata),
        .icache_resp   (icache_resp),
        .dcache_read   (dcache_read),
        .dcache_write  (dcache_write),
        .dcache_address(dcache_address),
        .dcache_wdata  (dcache_wdata),
        .dcache_rdata  (dcache_rdata),
        .dcache_resp   (dcache_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input lc3b_word obs, input lc3b_word exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input lc3b_line obs, input lc3b_line exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobes, address, wdata and both resps all low.
    task automatic chk_quiet(input string tag);
        chk1({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk1({tag, "_pmem_write"}, pmem_write, 1'b0);
        chk16({tag, "_pmem_address"}, pmem_address, 16'h0000);
        chk128({tag, "_pmem_wdata"}, pmem_wdata, 128'h0);
        chk1({tag, "_icache_resp"}, icache_resp, 1'b0);
        chk1({tag, "_dcache_resp"}, dcache_resp, 1'b0);
    endtask

    localparam lc3b_line LINE_A  = {16{8'hAA}};
    localparam lc3b_line LINE_W  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam lc3b_line LINE_B  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam lc3b_line LINE_W2 = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        icache_read    = 1'b0;
        icache_address = 16'h0000;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = 16'h0000;
        dcache_wdata   = 128'h0;
        pmem_rdata     = 128'h0;
        pmem_resp      = 1'b0;

        // Reset state: IDLE, everything low, resp ignored in IDLE
        tick();
        tick();
        rst        = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_B;
        settle();
        chk_quiet("reset_idle");
        chk128("reset_rdata_pass_i", icache_rdata, LINE_B);
        chk128("reset_rdata_pass_d", dcache_rdata, LINE_B);
        pmem_resp = 1'b0;

        // I-only read at 0x1230, response after 3 cycles
        tick();
        icache_read    = 1'b1;
        icache_address = 16'h1230;
        settle();
        chk1("i_read_no_strobe_in_idle", pmem_read, 1'b0);
        tick();
        chk1("i_read_strobe", pmem_read, 1'b1);
        chk1("i_read_no_write", pmem_write, 1'b0);
        chk16("i_read_addr", pmem_address, 16'h1230);
        chk1("i_read_resp_wait", icache_resp, 1'b0);
        tick();
        tick();
        chk1("i_read_strobe_held", pmem_read, 1'b1);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_A;
        settle();
        chk1("i_read_resp", icache_resp, 1'b1);
        chk128("i_read_rdata", icache_rdata, LINE_A);
        chk1("i_read_no_dresp", dcache_resp, 1'b0);
        tick();
        icache_read = 1'b0;
        settle();
        chk_quiet("i_read_after_idle");
        pmem_resp = 1'b0;

        // D write to 0x0040
        tick();
        dcache_write   = 1'b1;
        dcache_address = 16'h0040;
        dcache_wdata   = LINE_W;
        tick();
        chk1("d_write_strobe", pmem_write, 1'b1);
        chk1("d_write_no_read", pmem_read, 1'b0);
        chk16("d_write_addr", pmem_address, 16'h0040);
        chk128("d_write_wdata", pmem_wdata, LINE_W);
        pmem_resp = 1'b1;
        settle();
        chk1("d_write_resp", dcache_resp, 1'b1);
        chk1("d_write_no_iresp", icache_resp, 1'b0);
        tick();
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
        settle();
        chk_quiet("d_write_idle");

        // Simultaneous requests after reset: I, D, I under continuous contention
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        icache_read    = 1'b1;
        icache_address = 16'h1111;
        dcache_read    = 1'b1;
        dcache_address = 16'h2222;
        tick();
        chk16("tie1_grant_i_addr", pmem_address, 16'h1111);
        chk1("tie1_grant_i_read", pmem_read, 1'b1);
        pmem_resp = 1'b1;
        settle();
        chk1("tie1_iresp", icache_resp, 1'b1);
        chk1("tie1_no_dresp", dcache_resp, 1'b0);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk_quiet("tie1_gap");
        tick();
        chk16("tie2_grant_d_addr", pmem_address, 16'h2222);
        chk1("tie2_grant_d_read", pmem_read, 1'b1);
        pmem_resp = 1'b1;
        settle();
        chk1("tie2_dresp", dcache_resp, 1'b1);
        chk1("tie2_no_iresp", icache_resp, 1'b0);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk_quiet("tie2_gap");
        tick();
        chk16("tie3_grant_i_addr", pmem_address, 16'h1111);
        pmem_resp = 1'b1;
        tick();
        icache_read = 1'b0;
        dcache_read = 1'b0;
        pmem_resp   = 1'b0;
        settle();
        chk_quiet("tie3_gap");

        // D write arriving mid-SERVE_I is held off until after the I transaction
        tick();
        icache_read    = 1'b1;
        icache_address = 16'h3000;
        tick();
        dcache_write   = 1'b1;
        dcache_address = 16'h4000;
        dcache_wdata   = LINE_W2;
        settle();
        chk1("holdoff_no_write", pmem_write, 1'b0);
        chk16("holdoff_addr_i", pmem_address, 16'h3000);
        chk128("holdoff_no_wdata", pmem_wdata, 128'h0);
        tick();
        chk1("holdoff_no_write2", pmem_write, 1'b0);
        pmem_resp = 1'b1;
        tick();
        icache_read = 1'b0;
        pmem_resp   = 1'b0;
        settle();
        chk1("holdoff_gap_no_write", pmem_write, 1'b0);
        chk1("holdoff_gap_no_read", pmem_read, 1'b0);
        tick();
        chk1("holdoff_serve_d_write", pmem_write, 1'b1);
        chk16("holdoff_serve_d_addr", pmem_address, 16'h4000);
        chk128("holdoff_serve_d_wdata", pmem_wdata, LINE_W2);

        // Reset in SERVE_D before any response aborts it
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        pmem_resp = 1'b1;
        settle();
        chk_quiet("rst_abort");
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
        icache_read    = 1'b1;
        icache_address = 16'h5550;
        tick();
        chk1("post_rst_i_read", pmem_read, 1'b1);
        chk16("post_rst_i_addr", pmem_address, 16'h5550);
        pmem_resp = 1'b1;
        settle();
        chk1("post_rst_iresp", icache_resp, 1'b1);
        tick();
        pmem_resp = 1'b0;

        // Requester drop aborts SERVE_I without a response
        icache_address = 16'h6660;
        tick();
        chk1("abort_serve_i_read", pmem_read, 1'b1);
        icache_read = 1'b0;
        settle();
        chk1("abort_strobe_follows", pmem_read, 1'b0);
        tick();
        dcache_read    = 1'b1;
        dcache_address = 16'h7770;
        pmem_resp      = 1'b1;
        settle();
        chk_quiet("abort_idle");
        pmem_resp = 1'b0;
        tick();
        chk1("after_abort_d_read", pmem_read, 1'b1);
        chk16("after_abort_d_addr", pmem_address, 16'h7770);

        // Read and write together: write wins
        dcache_write = 1'b1;
        dcache_wdata = LINE_W;
        settle();
        chk1("rw_both_write", pmem_write, 1'b1);
        chk1("rw_both_no_read", pmem_read, 1'b0);
        pmem_resp = 1'b1;
        tick();
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
        settle();
        chk_quiet("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
